// File: rtl/move_queue_pkg.sv
// Shared snake-game definitions: direction codes, command/direction widths
// and the reversal helper used when filtering incoming commands.
package move_queue_pkg;

  localparam int unsigned DIR_W = 2;
  localparam int unsigned CMD_W = 4;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  // Opposite directions differ only in the upper code bit.
  function automatic logic is_reverse(input logic [DIR_W-1:0] a,
                                      input logic [DIR_W-1:0] b);
    return (a ^ 2'b10) == b;
  endfunction

endpackage

// File: rtl/move_queue_dir_fifo.sv
// dir_fifo: synchronous FIFO of direction codes.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        sync clear of pointers/count
//   push, pop    write wr_data / advance read pointer (caller guarantees legality)
//   wr_data      direction to enqueue
//   head, tail   oldest / newest stored entry (valid only when !empty)
//   full, empty  occupancy flags
module dir_fifo
  import move_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [DIR_W-1:0] wr_data,
  output logic [DIR_W-1:0] head,
  output logic [DIR_W-1:0] tail,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DIR_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  assign head  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - AW'(1)];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Push while full is only issued together with a pop; the write lands on
  // the slot the head is leaving, which is read before this edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_queue.sv
// move_queue: buffers snake direction commands between the EPP receiver and
// the game core. Rejects out-of-range codes, duplicates and 180-degree
// reversals of the last accepted direction; releases one direction per step.
// Optional drop statistics when MOVE_QUEUE_STATS_EN is defined.
// Ports:
//   clk, rst_n   mclk, async active-low reset
//   cmd_valid    one-cycle strobe qualifying cmd_data
//   cmd_data     command nibble (0..3 direction, others invalid)
//   flush        sync clear, dominates every other input
//   step         game move tick, consumes the next queued direction
//   dir          current heading
//   dir_chg      one-cycle pulse after a step that changed dir
//   full, empty  queue occupancy flags
//   drop_cnt     saturating rejected-command count (0 without stats)
module move_queue
  import move_queue_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [DIR_W-1:0] INIT_DIR = 2'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             flush,
  input  logic             step,
  output logic [DIR_W-1:0] dir,
  output logic             dir_chg,
  output logic             full,
  output logic             empty,
  output logic [7:0]       drop_cnt
);

  logic [DIR_W-1:0] fifo_head;
  logic [DIR_W-1:0] fifo_tail;
  logic [DIR_W-1:0] cmd_dir;
  logic [DIR_W-1:0] ref_dir;
  logic             cmd_legal;
  logic             push;
  logic             pop;

  assign cmd_dir = cmd_data[DIR_W-1:0];

  // Last accepted direction, taken from pre-pop state.
  assign ref_dir = empty ? dir : fifo_tail;

  assign cmd_legal = (cmd_data < CMD_W'(4)) &&
                     (cmd_dir != ref_dir) &&
                     !is_reverse(cmd_dir, ref_dir);

  assign pop  = step & ~flush & ~empty;
  // A simultaneous pop frees a slot, so a full queue may still accept.
  assign push = cmd_valid & ~flush & cmd_legal & (~full | pop);

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (cmd_dir),
    .head    (fifo_head),
    .tail    (fifo_tail),
    .full    (full),
    .empty   (empty)
  );

  // Queued entries always differ from their predecessor, so every pop is a
  // real heading change and dir_chg is simply the registered pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir     <= INIT_DIR;
      dir_chg <= 1'b0;
    end else if (flush) begin
      dir     <= INIT_DIR;
      dir_chg <= 1'b0;
    end else begin
      dir_chg <= pop;
      if (pop) dir <= fifo_head;
    end
  end

`ifdef MOVE_QUEUE_STATS_EN
  logic drop;

  assign drop = cmd_valid & ~flush & ~push;

  // Survives flush so statistics span game restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_move_queue.sv
module tb_move_queue;

  localparam int unsigned DEPTH = 4;
  localparam int          INIT  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [3:0] cmd_data;
  logic       flush;
  logic       step;
  logic [1:0] dir;
  logic       dir_chg;
  logic       full;
  logic       empty;
  logic [7:0] drop_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: queue of accepted directions plus heading state.
  int q[$];
  int m_dir;
  int m_chg;
  int m_drops;

  always #5 clk = ~clk;

  move_queue #(
    .DEPTH    (DEPTH),
    .INIT_DIR (2'd1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .flush     (flush),
    .step      (step),
    .dir       (dir),
    .dir_chg   (dir_chg),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_drops();
`ifdef MOVE_QUEUE_STATS_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".dir"},      32'(dir),      32'(m_dir));
    check({tag, ".dir_chg"},  32'(dir_chg),  32'(m_chg));
    check({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drops()));
  endtask

  task automatic model_reset();
    q.delete();
    m_dir   = INIT;
    m_chg   = 0;
    m_drops = 0;
  endtask

  // One clock of the model, written from the filtering rules directly.
  task automatic model_clock(input int v, input int d, input int s, input int f);
    int  last;
    bit  do_pop;
    bit  ok;
    if (f) begin
      q.delete();
      m_dir = INIT;
      m_chg = 0;
      return;
    end
    last   = (q.size() > 0) ? q[$] : m_dir;
    do_pop = s && (q.size() > 0);
    ok     = v && (d < 4) && (d != last) && (d != (last + 2) % 4) &&
             ((q.size() < DEPTH) || do_pop);
    m_chg = do_pop;
    if (do_pop) m_dir = q.pop_front();
    if (ok) q.push_back(d);
    else if (v && m_drops < 255) m_drops++;
  endtask

  task automatic cycle(input int v, input int d, input int s, input int f, input string tag);
    cmd_valid = v[0];
    cmd_data  = d[3:0];
    step      = s[0];
    flush     = f[0];
    model_clock(v, d, s, f);
    @(posedge clk);
    #1;
    check_all(tag);
    cmd_valid = 1'b0;
    step      = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    int v, d, s, f;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    flush     = 1'b0;
    step      = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle steps keep the initial heading
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, "t1_idle_step");
    check("t1_dir", 32'(dir), 32'd1);

    // 2: UP then LEFT released on consecutive steps
    cycle(1, 0, 0, 0, "t2_push_up");
    cycle(1, 3, 0, 0, "t2_push_left");
    cycle(0, 0, 1, 0, "t2_step1");
    check("t2_dir_up", 32'(dir), 32'd0);
    check("t2_chg1", 32'(dir_chg), 32'd1);
    cycle(0, 0, 1, 0, "t2_step2");
    check("t2_dir_left", 32'(dir), 32'd3);
    check("t2_chg2", 32'(dir_chg), 32'd1);
    cycle(0, 0, 0, 0, "t2_idle");

    // 3: reversal, duplicate and invalid code are all rejected
    cycle(0, 0, 0, 1, "t3_flush");
    cycle(1, 3, 0, 0, "t3_reverse");
    cycle(1, 1, 0, 0, "t3_dup");
    cycle(1, 9, 0, 0, "t3_invalid");
    check("t3_empty", 32'(empty), 32'd1);
`ifdef MOVE_QUEUE_STATS_EN
    check("t3_drops", 32'(drop_cnt), 32'd3);
`endif

    // 4: fill to DEPTH, overflow dropped, drain in order
    cycle(1, 0, 0, 0, "t4_push0");
    cycle(1, 1, 0, 0, "t4_push1");
    cycle(1, 0, 0, 0, "t4_push2");
    cycle(1, 1, 0, 0, "t4_push3");
    check("t4_full", 32'(full), 32'd1);
    cycle(1, 0, 0, 0, "t4_overflow");
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, "t4_drain");
      check("t4_drain_dir", 32'(dir), 32'(i % 2));
    end
    check("t4_empty", 32'(empty), 32'd1);

    // 5: push+step on a full queue, then push+step on an empty queue
    cycle(1, 0, 0, 0, "t5_fill0");
    cycle(1, 1, 0, 0, "t5_fill1");
    cycle(1, 0, 0, 0, "t5_fill2");
    cycle(1, 1, 0, 0, "t5_fill3");
    cycle(1, 2, 1, 0, "t5_full_push_step");
    check("t5_full_kept", 32'(full), 32'd1);
    check("t5_pop_dir", 32'(dir), 32'd0);
    cycle(0, 0, 0, 1, "t5_flush");
    cycle(1, 0, 1, 0, "t5_empty_push_step");
    check("t5_dir_held", 32'(dir), 32'd1);
    cycle(0, 0, 1, 0, "t5_next_step");
    check("t5_dir_up", 32'(dir), 32'd0);

    // 6: flush wins over push+step; then async reset mid-operation
    cycle(1, 1, 0, 0, "t6_push_a");
    cycle(1, 2, 0, 0, "t6_push_b");
    cycle(1, 9, 1, 1, "t6_flush_all");
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_dir", 32'(dir), 32'd1);
    cycle(1, 0, 0, 0, "t6_push_c");
    cycle(1, 3, 1, 0, "t6_push_step");
    cycle(1, 7, 0, 0, "t6_bad");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      v = int'($urandom_range(0, 1));
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      s = ($urandom_range(0, 3) == 0) ? 1 : 0;
      f = ($urandom_range(0, 49) == 0) ? 1 : 0;
      cycle(v, d, s, f, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
